// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative multiply/divide unit owning HI/LO, resolving one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier is zero.
module exe_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mf_req,
  input  logic            mt_hi,
  input  logic            mt_lo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic            stall
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r;
  logic                is_div_r, neg_a_r, neg_b_r;
  logic [2*XLEN-1:0]   acc_r, mcand_r;
  logic [XLEN-1:0]     mplier_r, rem_r, quo_r, dvsr_r;
  logic [XLEN-1:0]     hi_r, lo_r;
  logic                done_r, dbz_r;
  logic [XLEN:0]       rem_shift_s;
  logic [XLEN-1:0]     sub_s, rem_s, quo_s;
  logic                ge_s, calc_last_s;
  logic [2*XLEN-1:0]   prod_s;

  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic en);
    negate_if = en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Restoring-divide trial subtraction; the true difference always fits in XLEN bits when kept.
  assign rem_shift_s = {rem_r, quo_r[XLEN-1]};
  assign ge_s        = (rem_shift_s >= {1'b0, dvsr_r});
  assign sub_s       = rem_shift_s[XLEN-1:0] - dvsr_r;

  assign prod_s = (neg_a_r ^ neg_b_r) ? (~acc_r + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_r;
  assign quo_s  = negate_if(quo_r, neg_a_r ^ neg_b_r);
  // Remainder takes the dividend's sign; with a zero divisor it is the dividend itself.
  assign rem_s  = negate_if(rem_r, neg_a_r);

`ifdef MULDIV_EARLY_OUT_EN
  assign calc_last_s = (cnt_r == {{(CW-1){1'b0}}, 1'b1}) ||
                       (!is_div_r && (mplier_r[XLEN-1:1] == {(XLEN-1){1'b0}}));
`else
  assign calc_last_s = (cnt_r == {{(CW-1){1'b0}}, 1'b1});
`endif

  assign hi          = hi_r;
  assign lo          = lo_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign busy        = (state_r != IDLE);
  assign stall       = busy & (start | mf_req | mt_hi | mt_lo);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = CALC;
        else       state_s = IDLE;
      end
      CALC: begin
        if (calc_last_s) state_s = FIX;
        else             state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, per-bit iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r    <= {CW{1'b0}};
      is_div_r <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      acc_r    <= {(2*XLEN){1'b0}};
      mcand_r  <= {(2*XLEN){1'b0}};
      mplier_r <= {XLEN{1'b0}};
      rem_r    <= {XLEN{1'b0}};
      quo_r    <= {XLEN{1'b0}};
      dvsr_r   <= {XLEN{1'b0}};
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // op[0] set means unsigned; signed ops work on magnitudes and fix signs in FIX.
            is_div_r <= op[1];
            neg_a_r  <= ~op[0] & rs_data[XLEN-1];
            neg_b_r  <= ~op[0] & rt_data[XLEN-1];
            cnt_r    <= CW'(XLEN);
            acc_r    <= {(2*XLEN){1'b0}};
            mcand_r  <= {{XLEN{1'b0}}, negate_if(rs_data, ~op[0] & rs_data[XLEN-1])};
            mplier_r <= negate_if(rt_data, ~op[0] & rt_data[XLEN-1]);
            rem_r    <= {XLEN{1'b0}};
            quo_r    <= negate_if(rs_data, ~op[0] & rs_data[XLEN-1]);
            dvsr_r   <= negate_if(rt_data, ~op[0] & rt_data[XLEN-1]);
          end else begin
            if (mt_hi) hi_r <= rs_data;
            if (mt_lo) lo_r <= rs_data;
          end
        end
        CALC: begin
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          if (is_div_r) begin
            rem_r <= ge_s ? sub_s : rem_shift_s[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], ge_s};
          end else begin
            acc_r    <= mplier_r[0] ? (acc_r + mcand_r) : acc_r;
            mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
          end
        end
        FIX: begin
          if (is_div_r) begin
            hi_r  <= rem_s;
            lo_r  <= (dvsr_r == {XLEN{1'b0}}) ? {XLEN{1'b1}} : quo_s;
            dbz_r <= (dvsr_r == {XLEN{1'b0}});
          end else begin
            {hi_r, lo_r} <= prod_s;
          end
          done_r <= 1'b1;
          cnt_r  <= {CW{1'b0}};
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed cases plus random ops against an arithmetic model.
module tb_exe_muldiv;
  logic        clock = 1'b0;
  logic        reset;
  logic        start, mf_req, mt_hi, mt_lo;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero, stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  ro;
  logic [31:0] ra, rb;
  bit          seen;

  exe_muldiv #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mf_req(mf_req),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_by_zero(div_by_zero), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % follows the dividend.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = o[0] ? longint'({32'd0, a}) : longint'($signed(a));
    sb  = o[0] ? longint'({32'd0, b}) : longint'($signed(b));
    edz = 1'b0;
    if (!o[1]) begin
      p  = 64'(sa * sb);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      eh  = a;
      el  = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  // Edges from accept until done is visible.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    int k;
    logic [31:0] m;
    k = 0;
    m = (o == 2'b00 && b[31]) ? (~b + 32'd1) : b;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      return ((k < 1) ? 1 : k) + 1;
    end
`endif
    return 33 + int'(m[0] & 1'b0);
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit with_mf, input bit with_mt);
    logic [31:0] eh, el, hi_prev;
    logic        edz;
    int          lat, bcnt, cyc;
    model(o, a, b, eh, el, edz);
    lat     = exp_lat(o, b);
    hi_prev = hi;
    start   = 1'b1; op = o; rs_data = a; rt_data = b; mt_hi = with_mt;
    #1 chk({tag, "/stall_idle"}, {63'd0, stall}, 64'd0);
    @(negedge clock);
    start = 1'b0; mt_hi = 1'b0; rs_data = $urandom; rt_data = $urandom;
    if (with_mt) chk({tag, "/mt_ignored"}, {32'd0, hi}, {32'd0, hi_prev});
    bcnt = 0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (done) break;
      if (busy) bcnt++;
      if (with_mf && cyc >= 4) begin
        mf_req = 1'b1;
        #1 chk({tag, "/stall_busy"}, {63'd0, stall}, 64'd1);
      end
      @(negedge clock);
    end
    chk({tag, "/latency"}, 64'(cyc), 64'(lat));
    chk({tag, "/busy_cycles"}, 64'(bcnt), 64'(lat));
    chk({tag, "/busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "/dbz"}, {63'd0, div_by_zero}, {63'd0, edz});
    chk({tag, "/hilo"}, {hi, lo}, {eh, el});
    if (with_mf) chk({tag, "/stall_idle_mf"}, {63'd0, stall}, 64'd0);
    mf_req = 1'b0;
    @(negedge clock);
    chk({tag, "/done_pulse"}, {62'd0, done, div_by_zero}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
    #1;
    chk("reset/state", {hi, lo}, 64'd0);
    chk("reset/flags", {60'd0, busy, done, div_by_zero, stall}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max/const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("mult_neg/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
    chk("divu_zero/const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op("div_zero_neg", 2'b10, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf/const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_stall", 2'b11, 32'd1000, 32'd7, 1'b1, 1'b0);
    chk("divu_stall/const", {hi, lo}, 64'h0000_0006_0000_008E);

    // MTHI/MTLO in IDLE write at the edge; start beats a simultaneous mt_hi.
    mt_hi = 1'b1; rs_data = 32'hA5A5_1234;
    @(negedge clock);
    mt_hi = 1'b0; mt_lo = 1'b1; rs_data = 32'h5A5A_9876;
    @(negedge clock);
    mt_lo = 1'b0;
    chk("mt/hilo", {hi, lo}, 64'hA5A5_1234_5A5A_9876);
    run_op("start_mt", 2'b01, 32'd9, 32'd11, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case (i % 5)
        1:       rb = 32'($urandom_range(0, 15));
        2:       ra = 32'h8000_0000;
        3:       rb = 32'hFFFF_FFFF;
        default: ra = ra;
      endcase
      run_op("rand", ro, ra, rb, 1'b0, 1'b0);
    end

    // Reset in the middle of a multiply discards it.
    start = 1'b1; op = 2'b01; rs_data = 32'h1234_5678; rt_data = 32'h0FED_CBA9;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("rst/busy_before", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst/hilo", {hi, lo}, 64'd0);
    chk("rst/busy", {62'd0, busy, done}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      @(negedge clock);
    end
    chk("rst/no_done", {63'd0, seen}, 64'd0);
    run_op("rst_multu", 2'b01, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("rst_multu/const", {hi, lo}, 64'd6);

    run_op("multu_5x3", 2'b01, 32'd5, 32'd3, 1'b0, 1'b0);
    chk("multu_5x3/const", {hi, lo}, 64'd15);
    run_op("multu_x0", 2'b01, 32'd77, 32'd0, 1'b0, 1'b0);
    run_op("mult_negm", 2'b00, 32'd1000, 32'hFFFF_FFFE, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
